// File: rtl/id_symbol_serializer.sv
// Word-to-symbol serializer: loads a W-bit word and emits it MSB-first
// as 2-bit symbols on a valid/ready stream.
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   reset  - synchronous active-high reset, overrides everything
//   load   - start request, sampled only while idle
//   din    - word to serialize, captured on the accepted load edge
//   ready  - downstream accepts the symbol on a this cycle
//   a      - current symbol (IDLE_SYM when valid is low)
//   valid  - a holds a live symbol
//   busy   - serializer is not idle
//   done   - one-cycle pulse after the last symbol is accepted
//   count  - symbols accepted in the current word (saturates at W/2)
module id_symbol_serializer #(
  parameter int         W        = 18,
  parameter int         CW       = 4,
  parameter logic [1:0] IDLE_SYM = 2'b00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic [1:0]    a,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] NSYM = CW'(W / 2);
  localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [W-1:0]    shreg;
  logic [W-1:0]    shreg_n;
  logic [W-1:0]    shifted;
  logic [CW-1:0]   count_n;
  logic [1:0]      a_n;
  logic            valid_n;
  logic            busy_n;
  logic            done_n;

  assign shifted = shreg << 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      a     <= IDLE_SYM;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      count <= count_n;
      a     <= a_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so every port is a flop:
  // a_n is the symbol that will be at the top of the shift register
  // after this edge.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = count;
    a_n     = a;
    valid_n = valid;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        a_n     = IDLE_SYM;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (load) begin
          state_n = SEND;
          shreg_n = din;
          count_n = '0;
          a_n     = din[W-1:W-2];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        if (ready) begin
          shreg_n = shifted;
          if (count == LAST) begin
            state_n = DONE;
            count_n = NSYM;
            a_n     = IDLE_SYM;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            count_n = count + ONE;
            a_n     = shifted[W-1:W-2];
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        a_n     = IDLE_SYM;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        a_n     = IDLE_SYM;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
